// File: rtl/msx_bus_tracer_if.sv
// rtl/msx_bus_tracer_if.sv - Z80 bus taps and frame byte stream for msx_bus_tracer
interface msx_bus_tracer_if;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_mreq_n;
    logic        bus_iorq_n;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // master drives the CPU bus and sinks the byte stream; slave is the tracer
    modport master (
        output bus_addr, bus_data, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n,
        input  tx_data, tx_valid,
        output tx_ready
    );

    modport slave (
        input  bus_addr, bus_data, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n,
        output tx_data, tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/msx_bus_tracer.sv
// rtl/msx_bus_tracer.sv - Z80 bus-event tracer: window/mode filter, timestamped FIFO, 7-byte frames
// Optional address trigger gate enabled by defining BUS_TRACE_TRIGGER_EN.
module msx_bus_tracer #(
    parameter int         DEPTH    = 16,
    parameter int         TS_DIV   = 1,
    parameter logic [7:0] FLAG_HDR = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    msx_bus_tracer_if.slave          bus,
    input  logic                     arm,
    input  logic [15:0]              win_lo,
    input  logic [15:0]              win_hi,
    input  logic [3:0]               mode,
`ifdef BUS_TRACE_TRIGGER_EN
    input  logic [15:0]              trig_addr,
    output logic                     triggered,
`endif
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [15:0]              event_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic          arm_q;
    logic          arm_rise;
    logic [PW-1:0] ps;
    logic [15:0]   ts;

    logic          active;
    logic [1:0]    cur_type;
    logic          in_acc;
    logic [15:0]   rec_addr;
    logic [7:0]    rec_data;
    logic [1:0]    rec_type;
    logic [15:0]   rec_ts;
    logic          event_end;
    logic          in_win;
    logic          trig_ok;
    logic          qualify;

    logic [41:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          drop_pending;

    state_t        state;
    state_t        next_state;
    logic [2:0]    byte_idx;
    logic [2:0]    next_idx;
    logic [41:0]   frame_q;
    logic          xfer;
    logic          flags_xfer;

    assign arm_rise = arm & ~arm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q <= 1'b0;
            ps    <= '0;
            ts    <= '0;
        end else begin
            arm_q <= arm;
            if (arm_rise) begin
                ps <= '0;
                ts <= '0;
            end else if (clk_enable) begin
                if (ps == PW'(TS_DIV - 1)) begin
                    ps <= '0;
                    ts <= ts + 16'd1;
                end else begin
                    ps <= ps + 1'b1;
                end
            end
        end
    end

    assign active   = (~bus.bus_mreq_n | ~bus.bus_iorq_n) & (~bus.bus_rd_n | ~bus.bus_wr_n);
    assign cur_type = {~bus.bus_iorq_n, ~bus.bus_wr_n};

    // Address/data keep following the bus so a read records its final data;
    // the timestamp marks where the access began.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_acc   <= 1'b0;
            rec_addr <= '0;
            rec_data <= '0;
            rec_type <= '0;
            rec_ts   <= '0;
        end else if (clk_enable) begin
            in_acc <= active;
            if (active) begin
                rec_addr <= bus.bus_addr;
                rec_data <= bus.bus_data;
                rec_type <= cur_type;
                if (!in_acc) rec_ts <= ts;
            end
        end
    end

    assign event_end = clk_enable & in_acc & ~active;
    assign in_win    = (win_lo <= rec_addr) && (rec_addr <= win_hi);

`ifdef BUS_TRACE_TRIGGER_EN
    assign trig_ok = triggered | (rec_addr == trig_addr);

    always_ff @(posedge clk) begin
        if (reset || arm_rise)                         triggered <= 1'b0;
        else if (event_end && rec_addr == trig_addr)   triggered <= 1'b1;
    end
`else
    assign trig_ok = 1'b1;
`endif

    assign qualify    = event_end & arm & in_win & mode[rec_type] & trig_ok;
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == (AW + 1)'(DEPTH));
    assign push       = qualify & (~fifo_full | pop);
    assign drop       = qualify & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {rec_type, rec_addr, rec_data, rec_ts};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            drop_count   <= '0;
            event_count  <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                event_count <= event_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
            // a drop landing on the flags transfer must still be reported in a later frame
            if (drop)            drop_pending <= 1'b1;
            else if (flags_xfer) drop_pending <= 1'b0;
        end
    end

    assign xfer       = (state == S_SEND) & bus.tx_ready;
    assign flags_xfer = xfer & (byte_idx == 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            byte_idx <= '0;
            frame_q  <= '0;
        end else begin
            state    <= next_state;
            byte_idx <= next_idx;
            if (pop) frame_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = byte_idx;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_SEND;
                    next_idx   = 3'd0;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (byte_idx == 3'd6) begin
                        next_idx = 3'd0;
                        if (!fifo_empty) pop = 1'b1;
                        else             next_state = S_IDLE;
                    end else begin
                        next_idx = byte_idx + 3'd1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid = (state == S_SEND);
        bus.tx_data  = 8'h00;
        if (state == S_SEND) begin
            case (byte_idx)
                3'd0:    bus.tx_data = FLAG_HDR;
                3'd1:    bus.tx_data = {drop_pending, 5'b0, frame_q[41:40]};
                3'd2:    bus.tx_data = frame_q[39:32];
                3'd3:    bus.tx_data = frame_q[31:24];
                3'd4:    bus.tx_data = frame_q[23:16];
                3'd5:    bus.tx_data = frame_q[15:8];
                default: bus.tx_data = frame_q[7:0];
            endcase
        end
    end
endmodule

// File: tb/tb_msx_bus_tracer.sv
// tb/tb_msx_bus_tracer.sv - randomized bench for msx_bus_tracer with a frame-level reference model
module tb_msx_bus_tracer;
    localparam int         DEPTH  = 4;
    localparam int         TS_DIV = 3;
    localparam logic [7:0] HDR    = 8'hA5;

    typedef struct {
        logic [1:0]  typ;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] ts;
        logic        dp;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        arm;
    logic [15:0] win_lo;
    logic [15:0] win_hi;
    logic [3:0]  mode;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] event_count;
`ifdef BUS_TRACE_TRIGGER_EN
    logic [15:0] trig_addr = 16'h0000;
    logic        triggered;
`endif

    int   checks = 0;
    int   errors = 0;
    int   en_edges = 0;
    bit   arm_prev = 1'b0;
    bit   rst_at_edge = 1'b1;
    int   rdy_mode = 0;
    int   rx_total = 0;
    int   stop_at = 32'h7FFF_FFFF;
    bit   hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int   ev_m = 0;
    logic [7:0] rx_q [$];
    rec_t exp_q [$];

    msx_bus_tracer_if ifc ();

    msx_bus_tracer #(.DEPTH(DEPTH), .TS_DIV(TS_DIV), .FLAG_HDR(HDR)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .bus         (ifc),
        .arm         (arm),
        .win_lo      (win_lo),
        .win_hi      (win_hi),
        .mode        (mode),
`ifdef BUS_TRACE_TRIGGER_EN
        .trig_addr   (trig_addr),
        .triggered   (triggered),
`endif
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Enabled-cycle count since the last arm rise; the timestamp is this divided by TS_DIV.
    always @(posedge clk) begin
        rst_at_edge = reset;
        if (reset) begin
            en_edges = 0;
            arm_prev = 1'b0;
        end else begin
            if (arm && !arm_prev) en_edges = 0;
            else if (clk_enable)  en_edges++;
            arm_prev = arm;
        end
    end

    // Sink side: drives tx_ready, records transferred bytes, checks hold-while-stalled.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       ifc.tx_ready = 1'b0;
            1:       ifc.tx_ready = 1'b1;
            default: ifc.tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (rx_total >= stop_at) ifc.tx_ready = 1'b0;
        if (hold_prev && !rst_at_edge)
            chk("hold", {ifc.tx_valid, ifc.tx_data}, {1'b1, prev_data});
        if (!reset && ifc.tx_valid && ifc.tx_ready) begin
            rx_q.push_back(ifc.tx_data);
            rx_total++;
        end
        hold_prev = ifc.tx_valid && !ifc.tx_ready && !reset;
        prev_data = ifc.tx_data;
    end

    task automatic bus_idle();
        ifc.bus_addr   = 16'($urandom);
        ifc.bus_data   = 8'($urandom);
        ifc.bus_mreq_n = 1'b1;
        ifc.bus_iorq_n = 1'b1;
        ifc.bus_rd_n   = 1'b1;
        ifc.bus_wr_n   = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_enable = 1'($urandom);
        end
    endtask

    task automatic access(input logic io, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input int len);
        rec_t r;
        r.ts = 16'h0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            clk_enable     = 1'b1;
            ifc.bus_addr   = a;
            ifc.bus_data   = (i == len - 1) ? d : 8'($urandom);
            ifc.bus_mreq_n = io;
            ifc.bus_iorq_n = ~io;
            ifc.bus_rd_n   = wr;
            ifc.bus_wr_n   = ~wr;
            if (i == 0) r.ts = 16'(en_edges / TS_DIV);
            if (i < len - 1 && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                clk_enable   = 1'b0;
                ifc.bus_data = 8'($urandom);
            end
        end
        @(negedge clk);
        clk_enable = 1'b1;
        bus_idle();
        r.typ  = {io, wr};
        r.addr = a;
        r.data = d;
        r.dp   = 1'b0;
        if (arm && win_lo <= a && a <= win_hi && mode[{io, wr}]) begin
            exp_q.push_back(r);
            ev_m++;
        end
        @(negedge clk);
        clk_enable = 1'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((fifo_level != 0 || ifc.tx_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_drain"}, 64'(cyc < 3000), 64'd1);
    endtask

    task automatic check_frames(input string tag);
        int n = exp_q.size();
        int got;
        rec_t r;
        logic [55:0] act;
        logic [55:0] expf;
        wait_idle(tag);
        idle_cycles(20);
        chk({tag, "_bytes"}, 64'(rx_q.size()), 64'(7 * n));
        got = rx_q.size() / 7;
        for (int f = 0; f < n && f < got; f++) begin
            r    = exp_q.pop_front();
            expf = {HDR, r.dp, 5'b0, r.typ, r.addr, r.data, r.ts};
            act  = '0;
            for (int b = 0; b < 7; b++) act = {act[47:0], rx_q.pop_front()};
            chk($sformatf("%s_frame%0d", tag, f), 64'(act), 64'(expf));
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b0;
        arm        = 1'b0;
        win_lo     = 16'h0000;
        win_hi     = 16'hFFFF;
        mode       = 4'hF;
        ifc.tx_ready = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(ifc.tx_valid), 64'd0);
        chk("rst_data", 64'(ifc.tx_data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_flags", {overflow, drop_count, event_count}, 64'd0);
        reset = 1'b0;

        // single memory write, header latency
        arm = 1'b1;
        idle_cycles(5);
        access(1'b0, 1'b1, 16'hC000, 8'h3E, 2);
        chk("lat1_valid", 64'(ifc.tx_valid), 64'd0);
        @(negedge clk);
        chk("lat2_valid", 64'(ifc.tx_valid), 64'd1);
        chk("lat2_hdr", 64'(ifc.tx_data), 64'(HDR));
        rdy_mode = 1;
        check_frames("single");
        chk("evcnt_single", 64'(event_count), 64'(ev_m));

        // window and mode filter, inclusive edges, inverted window, disarmed
        win_lo = 16'h0400; win_hi = 16'h04FF; mode = 4'h1;
        access(1'b0, 1'b0, 16'h03FF, 8'h11, 1);
        access(1'b0, 1'b0, 16'h0416, 8'h22, 2);
        access(1'b0, 1'b0, 16'h0500, 8'h33, 1);
        access(1'b0, 1'b1, 16'h0420, 8'h44, 1);
        check_frames("window");
        win_lo = 16'h1000; win_hi = 16'h10FF; mode = 4'hF;
        access(1'b0, 1'b0, 16'h0FFF, 8'h01, 1);
        access(1'b0, 1'b0, 16'h1000, 8'h02, 1);
        access(1'b1, 1'b1, 16'h10FF, 8'h03, 1);
        access(1'b0, 1'b1, 16'h1100, 8'h04, 1);
        check_frames("edges");
        win_lo = 16'h0500; win_hi = 16'h0400;
        access(1'b0, 1'b1, 16'h0450, 8'h55, 1);
        win_lo = 16'h0000; win_hi = 16'hFFFF;
        arm = 1'b0;
        access(1'b0, 1'b1, 16'h8000, 8'h66, 1);
        check_frames("nocapture");
        chk("evcnt_filter", 64'(event_count), 64'(ev_m));

        // IO write and IO read with data changing during the access
        arm = 1'b1;
        idle_cycles(3);
        access(1'b1, 1'b1, 16'h00A8, 8'hF0, 2);
        access(1'b1, 1'b0, 16'h0099, 8'h5A, 4);
        check_frames("io");

        // random traffic under random backpressure
        rdy_mode = 2;
        for (int b = 0; b < 8; b++) begin
            win_lo = 16'($urandom_range(0, 16'h7FFF));
            win_hi = win_lo + 16'($urandom_range(0, 16'h7FFF));
            mode   = 4'($urandom);
            for (int k = 0; k < 3; k++)
                access(1'($urandom), 1'($urandom), 16'($urandom_range(0, 16'hFFFF)),
                       8'($urandom), $urandom_range(1, 4));
            check_frames($sformatf("rand%0d", b));
        end
        chk("evcnt_rand", 64'(event_count), 64'(ev_m));

        // overflow with the sink stalled
        win_lo = 16'h0000; win_hi = 16'hFFFF; mode = 4'hF;
        rdy_mode = 0;
        for (int k = 0; k < 7; k++) access(1'b0, 1'b1, 16'h2000 + 16'(k), 8'(k + 8'h70), 1);
        // one frame is held by the serializer, DEPTH more queue, the rest are lost
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        ev_m -= 2;
        exp_q[0].dp = 1'b1;
        chk("ovf_level", 64'(fifo_level), 64'(DEPTH));
        chk("ovf_drops", 64'(drop_count), 64'd2);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_evcnt", 64'(event_count), 64'(ev_m));
        rdy_mode = 1;
        check_frames("ovf");
        chk("ovf_keep", 64'(overflow), 64'd1);

        // reset while byte 3 is on the stream
        stop_at = rx_total + 3;
        access(1'b0, 1'b1, 16'h5A3C, 8'h99, 1);
        access(1'b0, 1'b0, 16'h1234, 8'h77, 1);
        begin
            int cyc = 0;
            while (rx_total < stop_at && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk("rst_reach", 64'(cyc < 500), 64'd1);
        end
        @(negedge clk);
        chk("rst_byte3", {ifc.tx_valid, ifc.tx_data}, {1'b1, 8'h3C});
        chk("rst_level_pre", 64'(fifo_level), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(ifc.tx_valid), 64'd0);
        chk("rst_mid_level", 64'(fifo_level), 64'd0);
        chk("rst_mid_stats", {overflow, drop_count, event_count}, 64'd0);
        reset = 1'b0;
        stop_at = 32'h7FFF_FFFF;
        exp_q.delete();
        rx_q.delete();
        ev_m = 0;
        idle_cycles(20);
        chk("rst_residual", 64'(rx_q.size()), 64'd0);
        chk("rst_idle_valid", 64'(ifc.tx_valid), 64'd0);

        // capture resumes after reset with a fresh timestamp
        idle_cycles(4);
        access(1'b0, 1'b1, 16'hBEEF, 8'hC3, 3);
        check_frames("post_rst");
        chk("evcnt_post", 64'(event_count), 64'(ev_m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
